// File: rtl/reset_sequencer.sv
// Staged reset release for one clock domain: hold, wait for MMCM lock, then release stages bit 0 first.
// Define LOCK_TIMEOUT_EN to retry from HOLD when lock does not arrive within LOCK_TIMEOUT cycles.
module reset_sequencer #(
   parameter int N_STAGES     = 3,
   parameter int HOLD_CYCLES  = 16,
   parameter int STAGE_GAP    = 8,
   parameter int LOCK_TIMEOUT = 1024
) (
   input  logic                clk_dst,
   input  logic                rst_in,
   input  logic                mmcm_locked,
   output logic [N_STAGES-1:0] rst_stage,
   output logic                seq_done,
   output logic                lock_timeout
);

   localparam int MAX_HG = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int MAX_C  = (MAX_HG > LOCK_TIMEOUT) ? MAX_HG : LOCK_TIMEOUT;
   localparam int CNT_W  = $clog2(MAX_C + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
`ifdef LOCK_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
`endif

   typedef enum logic [1:0] {HOLD, WAIT_LOCK, RELEASE, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [1:0]       rst_sync;
   logic [1:0]       lock_sync;
   logic             rst_hold;
   logic             locked_s;

   assign rst_hold = rst_sync[1];
   assign locked_s = lock_sync[1];
   assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;

   // Reset chain is set asynchronously and drains zeros; lock chain resets low.
   always_ff @(posedge clk_dst or posedge rst_in) begin
      if (rst_in) begin
         rst_sync  <= 2'b11;
         lock_sync <= 2'b00;
      end else begin
         rst_sync  <= {rst_sync[0], 1'b0};
         lock_sync <= {lock_sync[0], mmcm_locked};
      end
   end

`ifndef LOCK_TIMEOUT_EN
   assign lock_timeout = 1'b0;
`endif

   // Stages release by shifting zeros in from bit 0, so ordering holds by construction.
   always_ff @(posedge clk_dst or posedge rst_in) begin
      if (rst_in) begin
         state     <= HOLD;
         cnt       <= '0;
         rst_stage <= '1;
         seq_done  <= 1'b0;
`ifdef LOCK_TIMEOUT_EN
         lock_timeout <= 1'b0;
`endif
      end else begin
         case (state)
            HOLD: begin
               if (!rst_hold) begin
                  if (cnt == HOLD_LAST) begin
                     state <= WAIT_LOCK;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt_inc;
                  end
               end
            end
            WAIT_LOCK: begin
               if (locked_s) begin
                  state     <= RELEASE;
                  cnt       <= '0;
                  rst_stage <= rst_stage << 1;
               end
`ifdef LOCK_TIMEOUT_EN
               else if (cnt == TO_LAST) begin
                  state        <= HOLD;
                  cnt          <= '0;
                  lock_timeout <= 1'b1;
               end else begin
                  cnt <= cnt_inc;
               end
`endif
            end
            RELEASE: begin
               // Lock loss wins over a gap expiry on the same edge.
               if (!locked_s) begin
                  state     <= HOLD;
                  cnt       <= '0;
                  rst_stage <= '1;
                  seq_done  <= 1'b0;
               end else if (cnt == GAP_LAST) begin
                  cnt <= '0;
                  if (rst_stage == '0) begin
                     state    <= DONE;
                     seq_done <= 1'b1;
                  end else begin
                     rst_stage <= rst_stage << 1;
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end
            DONE: begin
               if (!locked_s) begin
                  state     <= HOLD;
                  cnt       <= '0;
                  rst_stage <= '1;
                  seq_done  <= 1'b0;
               end
            end
            default: state <= HOLD;
         endcase
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: event-level reference model feeds an expected-change queue, a monitor checks it.
module tb_reset_sequencer;

   localparam int N    = 3;
   localparam int HOLD = 16;
   localparam int GAP  = 8;
   localparam int LT   = 1024;
`ifdef LOCK_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int W = 32 + 2 + N;

   logic         clk_dst = 1'b0;
   logic         rst_in = 1'b0;
   logic         mmcm_locked = 1'b0;
   logic [N-1:0] rst_stage;
   logic         seq_done;
   logic         lock_timeout;

   reset_sequencer #(
      .N_STAGES(N), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .LOCK_TIMEOUT(LT)
   ) dut (
      .clk_dst(clk_dst), .rst_in(rst_in), .mmcm_locked(mmcm_locked),
      .rst_stage(rst_stage), .seq_done(seq_done), .lock_timeout(lock_timeout)
   );

   always #5 clk_dst = ~clk_dst;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   bit mon_en = 1'b0;
   logic [W-1:0] exp_q[$];

   // Reference model: phase 0 hold, 1 waiting for lock, 2 releasing, 3 done.
   int m_sync = 0, m_hold = 0, m_wait = 0, m_gap = 0, m_rel = 0, m_phase = 0;
   bit m_done = 1'b0, m_to = 1'b0;
   bit [1:0] m_lp = 2'b00;
   logic [N+1:0] m_prev = {2'b00, {N{1'b1}}};

   function automatic logic [N+1:0] m_out();
      logic [N-1:0] s;
      s = '1;
      for (int i = 0; i < N; i++) if (i < m_rel) s[i] = 1'b0;
      return {m_to, m_done, s};
   endfunction

   function automatic void m_push();
      logic [N+1:0] o;
      logic [W-1:0] t;
      o = m_out();
      if (o != m_prev) begin
         if (exp_q.size() > 0) begin
            t = exp_q[exp_q.size()-1];
            if (int'(t[W-1 -: 32]) == cyc) void'(exp_q.pop_back());
         end
         exp_q.push_back({32'(cyc), o});
         m_prev = o;
      end
   endfunction

   function automatic void model_reset();
      m_sync = 0; m_hold = 0; m_wait = 0; m_gap = 0; m_rel = 0; m_phase = 0;
      m_done = 1'b0; m_to = 1'b0; m_lp = 2'b00;
      m_push();
   endfunction

   function automatic void model_step();
      bit ls;
      ls = m_lp[1];
      m_lp = {m_lp[0], mmcm_locked};
      case (m_phase)
         0: begin
            if (m_sync < 2) m_sync++;
            else begin
               m_hold++;
               if (m_hold == HOLD) begin m_phase = 1; m_wait = 0; end
            end
         end
         1: begin
            if (ls) begin m_phase = 2; m_rel = 1; m_gap = 0; end
            else if (TO_EN) begin
               m_wait++;
               if (m_wait == LT) begin m_to = 1'b1; m_phase = 0; m_hold = 0; end
            end
         end
         default: begin
            if (!ls) begin m_phase = 0; m_hold = 0; m_rel = 0; m_done = 1'b0; end
            else if (m_phase == 2) begin
               m_gap++;
               if (m_gap == GAP) begin
                  m_gap = 0;
                  if (m_rel == N) begin m_phase = 3; m_done = 1'b1; end
                  else m_rel++;
               end
            end
         end
      endcase
      m_push();
   endfunction

   always @(posedge clk_dst) begin
      cyc++;
      if (!rst_in) model_step();
   end

   always @(posedge rst_in) model_reset();

   // Monitor: ordering invariant every cycle, and every output change against the queue.
   logic [N+1:0] obs, obs_prev;
   logic [W-1:0] head;
   always @(negedge clk_dst) begin
      if (mon_en) begin
         obs = {lock_timeout, seq_done, rst_stage};
         for (int k = 1; k < N; k++) begin
            checks++;
            if (!rst_stage[k] && rst_stage[k-1]) begin
               errors++;
               $display("FAIL order: cycle %0d got rst_stage=%b, required bit %0d high when bit %0d high",
                        cyc, rst_stage, k, k-1);
            end
         end
         while (exp_q.size() > 0 && int'(exp_q[0][W-1 -: 32]) < cyc) begin
            head = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL late: cycle %0d got %b, required %b at cycle %0d",
                     cyc, obs, head[N+1:0], int'(head[W-1 -: 32]));
         end
         if (obs !== obs_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected: cycle %0d got %b, required %b (no change due)", cyc, obs, obs_prev);
            end else begin
               head = exp_q.pop_front();
               if (head[N+1:0] !== obs || int'(head[W-1 -: 32]) != cyc) begin
                  errors++;
                  $display("FAIL change: got %b at cycle %0d, required %b at cycle %0d",
                           obs, cyc, head[N+1:0], int'(head[W-1 -: 32]));
               end
            end
            obs_prev = obs;
         end
      end
   end

   task automatic run(input int n);
      repeat (n) @(posedge clk_dst);
      #2;
   endtask

   task automatic do_reset(input logic lock);
      @(posedge clk_dst);
      #2;
      rst_in = 1'b1;
      mmcm_locked = lock;
      run(3);
      rst_in = 1'b0;
   endtask

   task automatic check_bit(input string name, input logic got, input logic req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %b, required %b", name, got, req);
      end
   endtask

   initial begin
      int k;
      int a, b, t;
      #1 rst_in = 1'b1;
      #1;
      check_bit("reset_stage", &rst_stage, 1'b1);
      check_bit("reset_done", seq_done, 1'b0);
      check_bit("reset_timeout", lock_timeout, 1'b0);
      obs_prev = {lock_timeout, seq_done, rst_stage};
      mon_en = 1'b1;

      // Nominal release with lock present throughout
      do_reset(1'b1);
      run(60);

      // Lock loss mid-sequence, then relock
      do_reset(1'b1);
      k = 0;
      while (rst_stage !== 3'b100 && k < 200) begin run(1); k++; end
      checks++;
      if (k >= 200) begin
         errors++;
         $display("FAIL wait_stage100: got rst_stage=%b, required 100 within 200 cycles", rst_stage);
      end
      mmcm_locked = 1'b0;
      run(5);
      mmcm_locked = 1'b1;
      run(70);

      // Late lock
      do_reset(1'b0);
      run(100);
      mmcm_locked = 1'b1;
      run(70);

      // Asynchronous 1 ns reset pulse while done
      @(posedge clk_dst);
      #2 rst_in = 1'b1;
      #0.5;
      check_bit("async_stage", &rst_stage, 1'b1);
      check_bit("async_done", seq_done, 1'b0);
      #0.5 rst_in = 1'b0;
      run(60);

      // No lock for longer than the timeout, then lock
      do_reset(1'b0);
      run(1100);
      mmcm_locked = 1'b1;
      run(70);

      // Randomized lock glitches
      t = 0;
      while (t < 10000) begin
         a = $urandom_range(20, 150);
         b = $urandom_range(1, 6);
         mmcm_locked = 1'b1;
         run(a);
         mmcm_locked = 1'b0;
         run(b);
         t += a + b;
      end
      mmcm_locked = 1'b1;
      run(80);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending: got %0d undelivered changes, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
